// File: rtl/decryption_cfg_arbiter.sv
// Round-robin arbiter sharing the decryption_regfile register port between two requesters.
// Define DECRYPTION_CFG_ARB_ADDR_CHECK_EN to reject unmapped addresses without touching the regfile.
module decryption_cfg_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int REG_WIDTH  = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [REG_WIDTH-1:0]  wdata0,
  input  logic [REG_WIDTH-1:0]  wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [REG_WIDTH-1:0]  rdata0,
  output logic [REG_WIDTH-1:0]  rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic                  reg_read,
  output logic                  reg_write,
  output logic [REG_WIDTH-1:0]  reg_wdata,
  input  logic [REG_WIDTH-1:0]  reg_rdata,
  input  logic                  reg_done,
  input  logic                  reg_error,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

`ifdef DECRYPTION_CFG_ARB_ADDR_CHECK_EN
  function automatic logic addr_mapped(input logic [ADDR_WIDTH-1:0] a);
    addr_mapped = (a == ADDR_WIDTH'(8'h00)) || (a == ADDR_WIDTH'(8'h10)) ||
                  (a == ADDR_WIDTH'(8'h12)) || (a == ADDR_WIDTH'(8'h14));
  endfunction
`endif

  state_t                state_r, state_s;
  logic [7:0]            cnt_r, cnt_s, cnt_inc_s;
  logic                  last_grant_r, last_grant_s;
  logic                  port_r, port_s;
  logic                  we_r, we_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [REG_WIDTH-1:0]  wdata_r, wdata_s;
  logic                  read_s, write_s;
  logic                  resp_s, resp_err_s;
  logic [REG_WIDTH-1:0]  resp_rdata_s;
  logic                  reg_read_r, reg_write_r, busy_r;
  logic                  ack0_r, ack1_r, err0_r, err1_r;
  logic [REG_WIDTH-1:0]  rdata0_r, rdata1_r;

  logic                  grant_s, sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [REG_WIDTH-1:0]  sel_wdata_s;

  // On a tie the port that did not win last time is granted.
  assign grant_s     = (req0 && req1) ? ~last_grant_r : req1;
  assign sel_we_s    = grant_s ? we1 : we0;
  assign sel_addr_s  = grant_s ? addr1 : addr0;
  assign sel_wdata_s = grant_s ? wdata1 : wdata0;

  // Next-state, latch and response decode.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    cnt_inc_s    = cnt_r + 8'd1;
    last_grant_s = last_grant_r;
    port_s       = port_r;
    we_s         = we_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    read_s       = 1'b0;
    write_s      = 1'b0;
    resp_s       = 1'b0;
    resp_rdata_s = '0;
    resp_err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req0 || req1) begin
          port_s       = grant_s;
          last_grant_s = grant_s;
          we_s         = sel_we_s;
          addr_s       = sel_addr_s;
          wdata_s      = sel_wdata_s;
          cnt_s        = 8'd0;
`ifdef DECRYPTION_CFG_ARB_ADDR_CHECK_EN
          if (!addr_mapped(sel_addr_s)) begin
            state_s    = ST_RESP;
            resp_s     = 1'b1;
            resp_err_s = 1'b1;
          end else begin
            state_s = ST_ISSUE;
            read_s  = ~sel_we_s;
            write_s = sel_we_s;
          end
`else
          state_s = ST_ISSUE;
          read_s  = ~sel_we_s;
          write_s = sel_we_s;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_s = cnt_inc_s;
        if (reg_done) begin
          state_s      = ST_RESP;
          resp_s       = 1'b1;
          resp_rdata_s = we_r ? '0 : reg_rdata;
          resp_err_s   = reg_error;
        end else if (cnt_inc_s == TIMEOUT_C) begin
          state_s    = ST_RESP;
          resp_s     = 1'b1;
          resp_err_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; response fields only move on an ack to that port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 8'd0;
      last_grant_r <= 1'b1;
      port_r       <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
      reg_read_r   <= 1'b0;
      reg_write_r  <= 1'b0;
      busy_r       <= 1'b0;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      rdata0_r     <= '0;
      rdata1_r     <= '0;
      err0_r       <= 1'b0;
      err1_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      last_grant_r <= last_grant_s;
      port_r       <= port_s;
      we_r         <= we_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      reg_read_r   <= read_s;
      reg_write_r  <= write_s;
      busy_r       <= (state_s != ST_IDLE);
      ack0_r       <= resp_s && !port_s;
      ack1_r       <= resp_s && port_s;
      if (resp_s && !port_s) begin
        rdata0_r <= resp_rdata_s;
        err0_r   <= resp_err_s;
      end
      if (resp_s && port_s) begin
        rdata1_r <= resp_rdata_s;
        err1_r   <= resp_err_s;
      end
    end
  end

  assign ack0      = ack0_r;
  assign ack1      = ack1_r;
  assign rdata0    = rdata0_r;
  assign rdata1    = rdata1_r;
  assign err0      = err0_r;
  assign err1      = err1_r;
  assign reg_addr  = addr_r;
  assign reg_read  = reg_read_r;
  assign reg_write = reg_write_r;
  assign reg_wdata = wdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_decryption_cfg_arbiter.sv
// Bench for decryption_cfg_arbiter with a small behavioural regfile (0x00 masked to 2 bits, 0x10/0x12/0x14 full).
module tb_decryption_cfg_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0]  addr0 = 8'h00, addr1 = 8'h00;
  logic [15:0] wdata0 = 16'h0000, wdata1 = 16'h0000;
  logic        ack0, ack1, err0, err1;
  logic [15:0] rdata0, rdata1;
  logic [7:0]  reg_addr;
  logic        reg_read, reg_write, busy;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata = 16'h0000;
  logic        reg_done = 1'b0, reg_error = 1'b0;

  typedef struct packed {
    logic        port;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          n_read = 0, n_write = 0;
  bit          stub_hang = 1'b0;
  logic [15:0] mem [4];
  logic [2:0]  rf_idx;

  decryption_cfg_arbiter #(.ADDR_WIDTH(8), .REG_WIDTH(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .reg_addr(reg_addr), .reg_read(reg_read), .reg_write(reg_write),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_done(reg_done),
    .reg_error(reg_error), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reg_read) n_read <= n_read + 1;
    if (reg_write) n_write <= n_write + 1;
  end

  always_comb begin
    case (reg_addr)
      8'h00:   rf_idx = 3'd0;
      8'h10:   rf_idx = 3'd1;
      8'h12:   rf_idx = 3'd2;
      8'h14:   rf_idx = 3'd3;
      default: rf_idx = 3'd4;
    endcase
  end

  // Regfile model: done one cycle after the strobe; stub_hang never answers.
  always @(posedge clk) begin
    reg_done  <= 1'b0;
    reg_error <= 1'b0;
    reg_rdata <= 16'h0000;
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= 16'h0000;
    end else if ((reg_read || reg_write) && !stub_hang) begin
      reg_done <= 1'b1;
      if (rf_idx == 3'd4) begin
        reg_error <= 1'b1;
      end else if (reg_write) begin
        mem[rf_idx[1:0]] <= (rf_idx == 3'd0) ? (reg_wdata & 16'h0003) : reg_wdata;
      end else begin
        reg_rdata <= mem[rf_idx[1:0]];
      end
    end
  end

  task automatic run_txn(input logic port, input logic we, input logic [7:0] addr,
                         input logic [15:0] wdata, output int lat, output bit stable,
                         output logic [15:0] rd, output logic er);
    int start;
    @(negedge clk);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end
    start  = cyc;
    lat    = -1;
    stable = 1'b1;
    rd     = 16'hxxxx;
    er     = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (reg_addr !== addr || reg_wdata !== wdata) stable = 1'b0;
      if (port ? ack1 : ack0) begin
        lat = cyc - start;
        rd  = port ? rdata1 : rdata0;
        er  = port ? err1 : err0;
        break;
      end
    end
    if (port) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack0, ack1, err0, err1, reg_read, reg_write, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b expected=0000000", {ack0, ack1, err0, err1, reg_read, reg_write, busy});
    end
    checks++;
    if ({rdata0, rdata1, reg_wdata, reg_addr} !== 56'h0) begin
      errors++;
      $display("FAIL reset_data got=%h expected=0", {rdata0, rdata1, reg_wdata, reg_addr});
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int lat; bit st; logic [15:0] rd; logic er; int w0;
    w0 = n_write;
    sb_q.push_back('{1'b0, 16'h0000, 1'b0});
    run_txn(1'b0, 1'b1, 8'h00, 16'h00FF, lat, st, rd, er);
    e = sb_q.pop_front();
    checks++;
    if (lat !== 3 || rd !== e.rdata || er !== e.err) begin
      errors++;
      $display("FAIL wr00_port0 lat=%0d rdata=%h err=%b expected lat=3 rdata=%h err=%b", lat, rd, er, e.rdata, e.err);
    end
    checks++;
    if (n_write - w0 !== 1) begin
      errors++;
      $display("FAIL wr00_strobes got=%0d expected=1", n_write - w0);
    end
    sb_q.push_back('{1'b1, 16'h0003, 1'b0});
    run_txn(1'b1, 1'b0, 8'h00, 16'h0000, lat, st, rd, er);
    e = sb_q.pop_front();
    checks++;
    if (lat !== 3 || rd !== e.rdata || er !== e.err) begin
      errors++;
      $display("FAIL rd00_port1 lat=%0d rdata=%h err=%b expected lat=3 rdata=%h err=%b", lat, rd, er, e.rdata, e.err);
    end
    run_txn(1'b0, 1'b1, 8'h10, 16'hA5A5, lat, st, rd, er);
    @(negedge clk);
    checks++;
    if (rdata1 !== 16'h0003 || err1 !== 1'b0 || rdata0 !== 16'h0000) begin
      errors++;
      $display("FAIL hold_rdata rdata1=%h err1=%b rdata0=%h expected 0003 0 0000", rdata1, err1, rdata0);
    end
  endtask

  task automatic test_tie();
    int start, a0a, a0b, a1;
    exp_t got;
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h14; wdata0 = 16'h5A5A;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h14; wdata1 = 16'h0000;
    sb_q.push_back('{1'b0, 16'h0000, 1'b0});
    sb_q.push_back('{1'b1, 16'h5A5A, 1'b0});
    sb_q.push_back('{1'b0, 16'h0000, 1'b0});
    start = cyc; a0a = -1; a0b = -1; a1 = -1;
    for (int i = 0; i < 30 && a0b < 0; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        got = '{ack1, ack1 ? rdata1 : rdata0, ack1 ? err1 : err0};
        e = sb_q.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL tie_scoreboard got port=%b rdata=%h err=%b expected port=%b rdata=%h err=%b",
                   got.port, got.rdata, got.err, e.port, e.rdata, e.err);
        end
      end
      if (ack0) begin
        if (a0a < 0) a0a = cyc - start;
        else begin a0b = cyc - start; req0 = 1'b0; end
      end
      if (ack1) begin a1 = cyc - start; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (a0a !== 3 || a1 !== 7 || a0b !== 11) begin
      errors++;
      $display("FAIL tie_timing ack0=%0d ack1=%0d ack0_again=%0d expected 3 7 11", a0a, a1, a0b);
    end
  endtask

  task automatic test_bad_addr();
    int lat, want_lat, want_rd, r0; bit st; logic [15:0] rd; logic er;
    r0 = n_read;
`ifdef DECRYPTION_CFG_ARB_ADDR_CHECK_EN
    want_lat = 1; want_rd = 0;
`else
    want_lat = 3; want_rd = 1;
`endif
    sb_q.push_back('{1'b0, 16'h0000, 1'b1});
    run_txn(1'b0, 1'b0, 8'h05, 16'h0000, lat, st, rd, er);
    e = sb_q.pop_front();
    checks++;
    if (lat !== want_lat || rd !== e.rdata || er !== e.err) begin
      errors++;
      $display("FAIL bad_addr lat=%0d rdata=%h err=%b expected lat=%0d rdata=%h err=%b", lat, rd, er, want_lat, e.rdata, e.err);
    end
    @(negedge clk);
    checks++;
    if (n_read - r0 !== want_rd) begin
      errors++;
      $display("FAIL bad_addr_strobes got=%0d expected=%0d", n_read - r0, want_rd);
    end
  endtask

  task automatic test_timeout();
    int start, lat, bad_busy;
    stub_hang = 1'b1;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10; wdata0 = 16'h0000;
    sb_q.push_back('{1'b0, 16'h0000, 1'b1});
    start = cyc; lat = -1;
    bad_busy = (busy !== 1'b0) ? 1 : 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (busy !== (k <= 17)) bad_busy++;
      if (ack0) begin
        lat  = cyc - start;
        req0 = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (rdata0 !== e.rdata || err0 !== e.err) begin
          errors++;
          $display("FAIL timeout_resp rdata=%h err=%b expected rdata=%h err=%b", rdata0, err0, e.rdata, e.err);
        end
      end
    end
    req0 = 1'b0;
    stub_hang = 1'b0;
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL timeout_lat got=%0d expected=17", lat);
    end
    checks++;
    if (bad_busy !== 0) begin
      errors++;
      $display("FAIL timeout_busy bad_cycles=%0d expected=0", bad_busy);
    end
  endtask

  task automatic test_reset_mid();
    int start, a0, a1, stray;
    stub_hang = 1'b1;
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 16'hBEEF;
    repeat (3) @(negedge clk);
    rst = 1'b1; req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || reg_write !== 1'b0 || ack1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state busy=%b reg_write=%b ack1=%b expected 0 0 0", busy, reg_write, ack1);
    end
    rst = 1'b0;
    stub_hang = 1'b0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack0 || ack1) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL reset_mid_stray_ack got=%0d expected=0", stray);
    end
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h12; wdata0 = 16'h0000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h00; wdata1 = 16'h0000;
    start = cyc; a0 = -1; a1 = -1;
    for (int i = 0; i < 20 && a1 < 0; i++) begin
      @(negedge clk);
      if (ack0 && a0 < 0) begin a0 = cyc - start; req0 = 1'b0; end
      if (ack1) begin a1 = cyc - start; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (a0 !== 3 || a1 !== 7) begin
      errors++;
      $display("FAIL reset_mid_tie ack0=%0d ack1=%0d expected 3 7", a0, a1);
    end
  endtask

  task automatic test_write_read_12();
    int lat; bit st; logic [15:0] rd; logic er;
    sb_q.push_back('{1'b0, 16'h0000, 1'b0});
    run_txn(1'b0, 1'b1, 8'h12, 16'h1234, lat, st, rd, er);
    e = sb_q.pop_front();
    checks++;
    if (lat !== 3 || rd !== e.rdata || er !== e.err || st !== 1'b1) begin
      errors++;
      $display("FAIL wr12 lat=%0d rdata=%h err=%b stable=%b expected lat=3 rdata=%h err=%b stable=1", lat, rd, er, st, e.rdata, e.err);
    end
    sb_q.push_back('{1'b0, 16'h1234, 1'b0});
    run_txn(1'b0, 1'b0, 8'h12, 16'hC3C3, lat, st, rd, er);
    e = sb_q.pop_front();
    checks++;
    if (lat !== 3 || rd !== e.rdata || er !== e.err || st !== 1'b1) begin
      errors++;
      $display("FAIL rd12 lat=%0d rdata=%h err=%b stable=%b expected lat=3 rdata=%h err=%b stable=1", lat, rd, er, st, e.rdata, e.err);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie();
    test_bad_addr();
    test_timeout();
    test_reset_mid();
    test_write_read_12();
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
